// File: rtl/uart_pkg.sv
// Shared UART register map, bit positions and the transmit scheduler state encoding.
// Imported by the scheduler and by later peripheral blocks that talk to the same UART.
package uart_pkg;

    localparam logic [31:0] UART_CTRL   = 32'h0;
    localparam logic [31:0] UART_STATUS = 32'h4;
    localparam logic [31:0] UART_BAUD   = 32'h8;
    localparam logic [31:0] UART_TXDATA = 32'hC;
    localparam logic [31:0] UART_RXDATA = 32'h10;

    localparam int CTRL_TX_EN      = 0;
    localparam int CTRL_RX_EN      = 1;
    localparam int STATUS_TX_BUSY  = 0;
    localparam int STATUS_RX_VALID = 1;

    typedef enum logic [6:0] {
        ST_INIT_BAUD = 7'b000_0001,
        ST_INIT_CTRL = 7'b000_0010,
        ST_IDLE      = 7'b000_0100,
        ST_POLL      = 7'b000_1000,
        ST_WRITE     = 7'b001_0000,
        ST_GAP       = 7'b010_0000,
        ST_REBAUD    = 7'b100_0000
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from the requester after last_i,
// wrapping around, and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    int               cand;
    logic [IDX_W-1:0] candIdx;
    logic             found;

    // Offset 1 is checked first so the previous winner has lowest priority.
    always_comb begin
        grant_o = '0;
        idx_o   = last_i;
        found   = 1'b0;
        cand    = 0;
        candIdx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand    = (int'(last_i) + i) % NUM_REQ;
            candIdx = IDX_W'(cand);
            if (en_i && !found && req_i[candIdx]) begin
                found            = 1'b1;
                grant_o[candIdx] = 1'b1;
                idx_o            = candIdx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Multi-requester transmit scheduler: programs the UART after reset, then feeds it bytes
// from NUM_REQ round-robin requesters, writing TXDATA only once the tx busy flag is clear.
module uart_tx_sched #(
    parameter  int          NUM_REQ   = 4,
    parameter  logic [31:0] BAUD_INIT = 32'h1B8,
    parameter  logic [31:0] CTRL_INIT = 32'h1,
    parameter  logic [31:0] BASE_ADDR = 32'h0,
    localparam int          IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic                 cfg_baud_we_i,
    input  logic [31:0]          cfg_baud_i,
    output logic                 uart_we_o,
    output logic [31:0]          uart_addr_o,
    output logic [31:0]          uart_wdata_o,
    input  logic [31:0]          uart_rdata_i,
    output logic                 init_done_o,
    output logic                 busy_o,
    output logic [IDX_W-1:0]     last_grant_o
);

    import uart_pkg::*;

    sched_state_e       state_q;
    logic [7:0]         txByte_q;
    logic [31:0]        baudShadow_q;
    logic               baudPend_q;
    logic               uartWe_q;
    logic [31:0]        uartAddr_q;
    logic [31:0]        uartWdata_q;
    logic               initDone_q;
    logic               busy_q;
    logic [IDX_W-1:0]   lastGrant_q;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grantIdx;
    logic               arbEn;
    logic               unusedRdata;

    assign unusedRdata = ^uart_rdata_i[31:1];

    // A pending baud change blocks grants so it reaches the UART before the next byte.
    assign arbEn = (state_q == ST_IDLE) && !baudPend_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid_i),
        .en_i    (arbEn),
        .last_i  (lastGrant_q),
        .grant_o (grant),
        .idx_o   (grantIdx)
    );

    assign req_ready_o  = grant;
    assign uart_we_o    = uartWe_q;
    assign uart_addr_o  = uartAddr_q;
    assign uart_wdata_o = uartWdata_q;
    assign init_done_o  = initDone_q;
    assign busy_o       = busy_q;
    assign last_grant_o = lastGrant_q;

    // Bus outputs are registered alongside the state they belong to, so each branch
    // loads the values for the state being entered. INIT_BAUD waits one cycle after
    // reset so the baud write is actually presented before moving on.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT_BAUD;
            txByte_q     <= '0;
            baudShadow_q <= BAUD_INIT;
            baudPend_q   <= 1'b0;
            uartWe_q     <= 1'b0;
            uartAddr_q   <= BASE_ADDR;
            uartWdata_q  <= '0;
            initDone_q   <= 1'b0;
            busy_q       <= 1'b1;
            lastGrant_q  <= IDX_W'(NUM_REQ - 1);
        end else begin
            uartWe_q    <= 1'b0;
            uartAddr_q  <= BASE_ADDR | UART_STATUS;
            uartWdata_q <= '0;
            busy_q      <= 1'b1;
            if (cfg_baud_we_i) begin
                baudShadow_q <= cfg_baud_i;
            end

            case (state_q)
                ST_INIT_BAUD: begin
                    uartWe_q <= 1'b1;
                    if (uartWe_q) begin
                        state_q     <= ST_INIT_CTRL;
                        uartAddr_q  <= BASE_ADDR | UART_CTRL;
                        uartWdata_q <= CTRL_INIT;
                    end else begin
                        uartAddr_q  <= BASE_ADDR | UART_BAUD;
                        uartWdata_q <= BAUD_INIT;
                    end
                end
                ST_INIT_CTRL: begin
                    state_q    <= ST_GAP;
                    initDone_q <= 1'b1;
                end
                ST_IDLE: begin
                    if (baudPend_q) begin
                        state_q     <= ST_REBAUD;
                        uartWe_q    <= 1'b1;
                        uartAddr_q  <= BASE_ADDR | UART_BAUD;
                        uartWdata_q <= baudShadow_q;
                        baudPend_q  <= 1'b0;
                    end else if (|grant) begin
                        state_q     <= ST_POLL;
                        txByte_q    <= req_data_i[{grantIdx, 3'b000} +: 8];
                        lastGrant_q <= grantIdx;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_POLL: begin
                    if (!uart_rdata_i[STATUS_TX_BUSY]) begin
                        state_q     <= ST_WRITE;
                        uartWe_q    <= 1'b1;
                        uartAddr_q  <= BASE_ADDR | UART_TXDATA;
                        uartWdata_q <= {24'h0, txByte_q};
                    end
                end
                ST_WRITE, ST_REBAUD: begin
                    state_q <= ST_GAP;
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_INIT_BAUD;
                end
            endcase

            // A new divider arriving as the old one is taken keeps the request pending.
            if (cfg_baud_we_i) begin
                baudPend_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched with a simple UART register model
// whose tx busy flag can be forced or held for a programmable number of cycles.
module tb_uart_tx_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_ready_o;
    logic        cfg_baud_we_i;
    logic [31:0] cfg_baud_i;
    logic        uart_we_o;
    logic [31:0] uart_addr_o;
    logic [31:0] uart_wdata_o;
    logic [31:0] uart_rdata_i;
    logic        init_done_o;
    logic        busy_o;
    logic [1:0]  last_grant_o;

    int checks   = 0;
    int failures = 0;

    int          busyLen   = 0;
    int          busyCnt   = 0;
    logic        forceBusy = 1'b0;
    logic [31:0] wrAddr[$];
    logic [31:0] wrData[$];
    logic [7:0]  expA[4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    int          weSeen;

    uart_tx_sched #(
        .NUM_REQ   (4),
        .BAUD_INIT (32'h1B8),
        .CTRL_INIT (32'h1),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_data_i    (req_data_i),
        .req_ready_o   (req_ready_o),
        .cfg_baud_we_i (cfg_baud_we_i),
        .cfg_baud_i    (cfg_baud_i),
        .uart_we_o     (uart_we_o),
        .uart_addr_o   (uart_addr_o),
        .uart_wdata_o  (uart_wdata_o),
        .uart_rdata_i  (uart_rdata_i),
        .init_done_o   (init_done_o),
        .busy_o        (busy_o),
        .last_grant_o  (last_grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: STATUS[0] reads busy while a byte is shifting out or when forced.
    assign uart_rdata_i = (uart_addr_o == 32'h4) ? {31'b0, (busyCnt != 0) || forceBusy} : 32'h0;

    always @(posedge clk) begin
        if (uart_we_o) begin
            wrAddr.push_back(uart_addr_o);
            wrData.push_back(uart_wdata_o);
        end
        if (rst) begin
            busyCnt <= 0;
        end else if (uart_we_o && uart_addr_o == 32'hC) begin
            busyCnt <= busyLen;
        end else if (busyCnt != 0) begin
            busyCnt <= busyCnt - 1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data);
        req_valid_i = valid;
        req_data_i  = data;
    endtask

    task automatic serviceRequests(input string tag, input int budget);
        logic [3:0] acc;
        for (int i = 0; i < budget && req_valid_i != 4'b0; i++) begin
            #3;
            acc = req_valid_i & req_ready_o;
            @(posedge clk);
            #1;
            req_valid_i = req_valid_i & ~acc;
        end
        checkOutput(tag, {28'h0, req_valid_i}, 32'h0);
    endtask

    task automatic waitWrites(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && wrAddr.size() < n; i++) tick();
        checkOutput(tag, 32'(wrAddr.size()), 32'(n));
    endtask

    task automatic waitIdle(input string tag, input int budget);
        for (int i = 0; i < budget && (busy_o !== 1'b0 || busyCnt != 0); i++) tick();
        checkOutput(tag, {31'h0, busy_o}, 32'h0);
    endtask

    function automatic logic [31:0] logAddr(input int i);
        return (i < wrAddr.size()) ? wrAddr[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] logData(input int i);
        return (i < wrData.size()) ? wrData[i] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        rst           = 1'b1;
        cfg_baud_we_i = 1'b0;
        cfg_baud_i    = 32'h0;
        applyStimulus(4'b0, 32'h0);

        // Reset values
        tick(); tick(); tick();
        checkOutput("rst_we", {31'h0, uart_we_o}, 32'h0);
        checkOutput("rst_addr", uart_addr_o, 32'h0);
        checkOutput("rst_wdata", uart_wdata_o, 32'h0);
        checkOutput("rst_ready", {28'h0, req_ready_o}, 32'h0);
        checkOutput("rst_init_done", {31'h0, init_done_o}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy_o}, 32'h1);
        checkOutput("rst_last", {30'h0, last_grant_o}, 32'h3);

        // Init sequence: BAUD write, CTRL write, then init_done
        wrAddr.delete(); wrData.delete();
        rst = 1'b0;
        tick();
        checkOutput("init_baud_we", {31'h0, uart_we_o}, 32'h1);
        checkOutput("init_baud_addr", uart_addr_o, 32'h8);
        checkOutput("init_baud_data", uart_wdata_o, 32'h1B8);
        tick();
        checkOutput("init_ctrl_we", {31'h0, uart_we_o}, 32'h1);
        checkOutput("init_ctrl_addr", uart_addr_o, 32'h0);
        checkOutput("init_ctrl_data", uart_wdata_o, 32'h1);
        checkOutput("init_done_early", {31'h0, init_done_o}, 32'h0);
        tick();
        checkOutput("init_done", {31'h0, init_done_o}, 32'h1);
        checkOutput("init_gap_we", {31'h0, uart_we_o}, 32'h0);
        tick();
        checkOutput("init_idle_busy", {31'h0, busy_o}, 32'h0);
        tick(); tick();
        checkOutput("init_write_count", 32'(wrAddr.size()), 32'h2);

        // Four simultaneous requesters with a slow UART: order starts after last=3
        busyLen = 20;
        wrAddr.delete(); wrData.delete();
        applyStimulus(4'hF, {8'hA3, 8'hA2, 8'hA1, 8'hA0});
        serviceRequests("rr4_accept", 300);
        waitWrites("rr4_count", 4, 300);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rr4_addr%0d", i), logAddr(i), 32'hC);
            checkOutput($sformatf("rr4_data%0d", i), logData(i), {24'h0, expA[i]});
        end
        checkOutput("rr4_last", {30'h0, last_grant_o}, 32'h3);

        // Requesters 1 and 2 after last=3
        waitIdle("rr2_idle", 100);
        wrAddr.delete(); wrData.delete();
        applyStimulus(4'b0110, {8'h00, 8'hB2, 8'hB1, 8'h00});
        serviceRequests("rr2_accept", 200);
        waitWrites("rr2_count", 2, 200);
        checkOutput("rr2_data0", logData(0), 32'hB1);
        checkOutput("rr2_data1", logData(1), 32'hB2);
        checkOutput("rr2_last", {30'h0, last_grant_o}, 32'h2);

        // Single byte from requester 0 with UART idle: exact 4-cycle cadence
        busyLen = 0;
        waitIdle("one_idle", 100);
        wrAddr.delete(); wrData.delete();
        applyStimulus(4'b0001, 32'h0000_0055);
        #1;
        checkOutput("one_ready", {28'h0, req_ready_o}, 32'h1);
        tick();
        applyStimulus(4'b0000, 32'h0);
        checkOutput("one_poll_we", {31'h0, uart_we_o}, 32'h0);
        checkOutput("one_poll_addr", uart_addr_o, 32'h4);
        checkOutput("one_poll_ready", {28'h0, req_ready_o}, 32'h0);
        checkOutput("one_last", {30'h0, last_grant_o}, 32'h0);
        tick();
        checkOutput("one_write_we", {31'h0, uart_we_o}, 32'h1);
        checkOutput("one_write_addr", uart_addr_o, 32'hC);
        checkOutput("one_write_data", uart_wdata_o, 32'h55);
        tick();
        checkOutput("one_gap_we", {31'h0, uart_we_o}, 32'h0);
        checkOutput("one_gap_busy", {31'h0, busy_o}, 32'h1);
        tick();
        checkOutput("one_idle_busy", {31'h0, busy_o}, 32'h0);
        checkOutput("one_count", 32'(wrAddr.size()), 32'h1);

        // STATUS busy held for 100 cycles keeps the scheduler polling
        forceBusy = 1'b1;
        applyStimulus(4'b1000, 32'h7700_0000);
        #1;
        checkOutput("hold_ready", {28'h0, req_ready_o}, 32'h8);
        tick();
        applyStimulus(4'b0000, 32'h0);
        weSeen = 0;
        for (int i = 0; i < 100; i++) begin
            if (uart_we_o !== 1'b0) weSeen++;
            tick();
        end
        checkOutput("hold_no_we", 32'(weSeen), 32'h0);
        checkOutput("hold_busy", {31'h0, busy_o}, 32'h1);
        forceBusy = 1'b0;
        tick();
        checkOutput("hold_write_we", {31'h0, uart_we_o}, 32'h1);
        checkOutput("hold_write_addr", uart_addr_o, 32'hC);
        checkOutput("hold_write_data", uart_wdata_o, 32'h77);

        // Two baud updates during POLL: only the last is written, before the next grant
        waitIdle("baud_idle", 50);
        wrAddr.delete(); wrData.delete();
        forceBusy = 1'b1;
        applyStimulus(4'b0001, 32'h0000_0011);
        #1;
        checkOutput("baud_ready0", {28'h0, req_ready_o}, 32'h1);
        tick();
        applyStimulus(4'b0010, 32'h0000_2200);
        cfg_baud_we_i = 1'b1;
        cfg_baud_i    = 32'h1B8;
        tick();
        cfg_baud_i    = 32'h36;
        tick();
        cfg_baud_we_i = 1'b0;
        cfg_baud_i    = 32'h0;
        tick(); tick();
        forceBusy = 1'b0;
        serviceRequests("baud_accept", 50);
        waitWrites("baud_count", 3, 100);
        checkOutput("baud_w0_addr", logAddr(0), 32'hC);
        checkOutput("baud_w0_data", logData(0), 32'h11);
        checkOutput("baud_w1_addr", logAddr(1), 32'h8);
        checkOutput("baud_w1_data", logData(1), 32'h36);
        checkOutput("baud_w2_addr", logAddr(2), 32'hC);
        checkOutput("baud_w2_data", logData(2), 32'h22);

        // One-cycle reset while polling drops the byte and reruns init
        waitIdle("rstmid_idle", 50);
        wrAddr.delete(); wrData.delete();
        forceBusy = 1'b1;
        applyStimulus(4'b0100, 32'h0099_0000);
        tick();
        applyStimulus(4'b0000, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("rstmid_we_during", {31'h0, uart_we_o}, 32'h0);
        tick();
        rst = 1'b0;
        forceBusy = 1'b0;
        checkOutput("rstmid_we_after", {31'h0, uart_we_o}, 32'h0);
        checkOutput("rstmid_init_done", {31'h0, init_done_o}, 32'h0);
        checkOutput("rstmid_last", {30'h0, last_grant_o}, 32'h3);
        tick();
        checkOutput("rstmid_baud_addr", uart_addr_o, 32'h8);
        checkOutput("rstmid_baud_data", uart_wdata_o, 32'h1B8);
        tick();
        checkOutput("rstmid_ctrl_addr", uart_addr_o, 32'h0);
        checkOutput("rstmid_ctrl_data", uart_wdata_o, 32'h1);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("rstmid_init_done2", {31'h0, init_done_o}, 32'h1);
        checkOutput("rstmid_count", 32'(wrAddr.size()), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Multi-requester transmit scheduler for the memory-mapped UART peripheral.
- Owns the UART register port (we/addr/wdata/rdata).
- After reset it programs BAUD and CTRL, then accepts bytes from NUM_REQ requesters. Arbitration is round-robin.
- Each byte is written to TXDATA only once STATUS[0] (tx busy) reads 0.
- Sits between the SoC debug/print sources and the UART, in place of direct CPU writes.

Parameters:
- NUM_REQ, 4, number of byte requesters (2..8).
- BAUD_INIT, 32'h1B8, divider written to BAUD at init (115200 at system clock).
- CTRL_INIT, 32'h1, value written to CTRL at init (bit0 tx enable, bit1 rx enable).
- BASE_ADDR, 32'h0, UART base; addr_o = BASE_ADDR | offset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid_i  in  NUM_REQ  per-requester byte valid
- req_data_i  in  8*NUM_REQ  per-requester byte, requester k at [8k+7:8k]
- req_ready_o  out  NUM_REQ  one-hot, 1-cycle acceptance pulse
- cfg_baud_we_i  in  1  request new baud divider
- cfg_baud_i  in  32  new baud divider value
- uart_we_o  out  1  UART register write enable
- uart_addr_o  out  32  UART register address
- uart_wdata_o  out  32  UART register write data
- uart_rdata_i  in  32  UART combinational read data for uart_addr_o
- init_done_o  out  1  init writes complete
- busy_o  out  1  state != IDLE
- last_grant_o  out  $clog2(NUM_REQ)  index of last accepted requester

Behaviour:
- Interface: one clock (clk); rst synchronous, active-high.
- Offsets: CTRL 0x0, STATUS 0x4, BAUD 0x8, TXDATA 0xC.
- Reset values while rst=1: uart_we_o=0, uart_addr_o=BASE_ADDR, uart_wdata_o=0, req_ready_o=0, init_done_o=0, busy_o=1, last_grant_o=NUM_REQ-1, baud_pend=0, state=INIT_BAUD.
- All outputs are registered or decoded from registered state only. No combinational path from req_valid_i to uart_*.
- INIT_BAUD: we=1, addr=+0x8, wdata=BAUD_INIT, 1 cycle -> INIT_CTRL.
- INIT_CTRL: we=1, addr=+0x0, wdata=CTRL_INIT, 1 cycle -> GAP. init_done_o=1 from the next cycle until reset.
- IDLE: we=0, addr=+0x4.
  - If baud_pend=1 -> REBAUD. baud_pend has priority over requests.
  - Else if any req_valid_i -> round-robin grant, searching from last_grant+1 upward with wrap.
  - On grant: pulse req_ready_o[k] that cycle, latch req_data byte k into tx_byte, update last_grant_o, go to POLL.
  - Acceptance occurs exactly when req_valid_i[k] & req_ready_o[k].
- POLL: we=0, addr=+0x4. Sample uart_rdata_i[0] each cycle; stay while 1, go to WRITE when 0. No timeout.
- WRITE: we=1, addr=+0xC, wdata={24'h0,tx_byte}, exactly 1 cycle -> GAP.
- GAP: we=0, addr=+0x4, 1 cycle -> IDLE. Guarantees a we=0 cycle after every write so the UART launches/clears its tx flag.
- REBAUD: we=1, addr=+0x8, wdata=baud_shadow, clear baud_pend -> GAP.
- cfg_baud_we_i in any state: baud_shadow<=cfg_baud_i, baud_pend<=1.
  - A repeat before it is applied overwrites the pending value; only the last is written.
  - cfg_baud_we_i in the same cycle REBAUD clears pend: the new value wins and pend stays 1.
- Requests seen before init completes are held (no ready) until IDLE.
- A requester dropping valid before grant loses nothing; no grant is issued to a low valid.
- Minimum byte cadence with the UART idle: IDLE, POLL, WRITE, GAP = 4 cycles; actual cadence is set by UART busy time.
- Reset mid-transfer: byte in tx_byte is discarded, init is re-run; no partial write (we forced 0 during rst).

Decomposition:
- uart_pkg:
  - Register offsets (UART_CTRL/STATUS/BAUD/TXDATA/RXDATA).
  - CTRL/STATUS bit positions (TX_EN=0, RX_EN=1, TX_BUSY=0, RX_VALID=1).
  - State encoding of uart_tx_sched (one-hot, 7 states).
- Sub-module rr_arbiter:
  - Inputs NUM_REQ-bit request, enable, last index.
  - Outputs one-hot grant and encoded index.
  - Combinational, reused by later peripheral arbiters.

Test Plan:
- Reset release -> cycle 1: write 0x8=0x1B8; cycle 2: write 0x0=0x1; init_done_o=1 on cycle 3; no other writes.
- Req0 sends 0x55, UART model STATUS[0]=0 -> ready[0] pulse, POLL 1 cycle, TXDATA write 0x55, GAP, IDLE.
- All four valid with bytes 0xA0..0xA3, model busy 20 cycles per byte -> TXDATA order A0,A1,A2,A3; then req1,req2 valid only after last=3 -> order 1,2.
- STATUS[0] held 1 for 100 cycles -> scheduler stays in POLL, uart_we_o=0 throughout, writes TXDATA on cycle after STATUS[0]=0.
- cfg_baud_we_i with 0x1B8 then 0x36 during a POLL -> after GAP, single BAUD write 0x36 precedes next grant.
- rst asserted for 1 cycle in POLL -> uart_we_o=0 that cycle, pending byte never written, init sequence repeats.
